hbm_rd_arbiter: RTL

HBM_RD_ARBITER -- requirements
Module: hbm_rd_arbiter

---
 rtl/hbm_rd_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/hbm_rd_arbiter.sv
// hbm_rd_arbiter: round-robin arbiter sharing one HBM AXI4 read port among NUM_REQ requesters
module hbm_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W = 48,
  parameter int DATA_W = 256,
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      axis_clk,
  input  logic                      rst,
  input  logic [NUM_REQ*ADDR_W-1:0] s_axi_araddr,
  input  logic [NUM_REQ*8-1:0]      s_axi_arlen,
  input  logic [NUM_REQ*3-1:0]      s_axi_arsize,
  input  logic [NUM_REQ*2-1:0]      s_axi_arburst,
  input  logic [NUM_REQ-1:0]        s_axi_arvalid,
  output logic [NUM_REQ-1:0]        s_axi_arready,
  output logic [NUM_REQ-1:0]        s_axi_rvalid,
  input  logic [NUM_REQ-1:0]        s_axi_rready,
  output logic [NUM_REQ-1:0]        s_axi_rlast,
  output logic [DATA_W-1:0]         s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      len_err
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  localparam logic [IDW:0] NREQ = (IDW+1)'(NUM_REQ);
  state_t state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d, rr_ptr_q, rr_ptr_d, off, pick, grant_inc;
  logic [IDW:0] pick_sum;
  logic [NUM_REQ-1:0] rot, sel;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic len_err_q, len_err_d, ar_hs, r_hs;
  // rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner's offset
  always_comb begin
    rot = NUM_REQ'({s_axi_arvalid, s_axi_arvalid} >> rr_ptr_q);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = IDW'(k);
    pick_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    pick = pick_sum >= NREQ ? IDW'(pick_sum - NREQ) : IDW'(pick_sum);
    grant_inc = grant_q == IDW'(NUM_REQ - 1) ? '0 : grant_q + 1'b1;
    sel = NUM_REQ'(1) << grant_q;
  end
  always_comb begin
    m_axi_araddr = '0;
    m_axi_arlen = '0;
    m_axi_arsize = '0;
    m_axi_arburst = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant_q == IDW'(i)) begin
        m_axi_araddr = s_axi_araddr[i*ADDR_W +: ADDR_W];
        m_axi_arlen = s_axi_arlen[i*8 +: 8];
        m_axi_arsize = s_axi_arsize[i*3 +: 3];
        m_axi_arburst = s_axi_arburst[i*2 +: 2];
      end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d = len_err_q;
    ar_hs = state_q == ADDR && s_axi_arvalid[grant_q] && m_axi_arready;
    r_hs = state_q == DATA && m_axi_rvalid && s_axi_rready[grant_q];
    m_axi_arvalid = state_q == ADDR && s_axi_arvalid[grant_q];
    s_axi_arready = state_q == ADDR && m_axi_arready ? sel : '0;
    m_axi_rready = state_q == DATA && s_axi_rready[grant_q];
    s_axi_rvalid = state_q == DATA && m_axi_rvalid ? sel : '0;
    s_axi_rlast = state_q == DATA && m_axi_rlast ? sel : '0;
    s_axi_rdata = m_axi_rdata;
    s_axi_rresp = m_axi_rresp;
    busy = state_q != IDLE;
    if (state_q == IDLE && |s_axi_arvalid) begin
      state_d = ADDR;
      grant_d = pick;
    end
    if (ar_hs) begin
      state_d = DATA;
      beat_cnt_d = m_axi_arlen;
    end else if (state_q == ADDR && !s_axi_arvalid[grant_q]) state_d = IDLE;
    // rlast must coincide exactly with the countdown reaching zero
    if (r_hs) begin
      beat_cnt_d = beat_cnt_q == 8'd0 ? beat_cnt_q : beat_cnt_q - 1'b1;
      if (m_axi_rlast != (beat_cnt_q == 8'd0)) len_err_d = 1'b1;
      if (m_axi_rlast) begin
        state_d = IDLE;
        rr_ptr_d = grant_inc;
      end
    end
  end
  always_ff @(posedge axis_clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      beat_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q <= len_err_d;
    end
  end
  assign grant_id = grant_q;
  assign len_err = len_err_q;
endmodule
